// File: rtl/bcd_alu_datapath_if.sv
// Command/display bus between the controller and the BCD ALU datapath.
// Covers the 4-phase req/ack command channel and the byte-wide display outputs.
interface bcd_alu_datapath_if;
  logic       cmd_req;
  logic [2:0] cmd;
  logic [7:0] bcd_input_data;
  logic       cmd_ack;
  logic       busy;
  logic [7:0] bcd_output_data;
  logic       carry;
  logic       err;

  modport master (
    output cmd_req, cmd, bcd_input_data,
    input  cmd_ack, busy, bcd_output_data, carry, err
  );

  modport slave (
    input  cmd_req, cmd, bcd_input_data,
    output cmd_ack, busy, bcd_output_data, carry, err
  );
endinterface

// File: rtl/bcd_alu_datapath.sv
// Digit-serial packed-BCD add/subtract datapath with operand registers A and B,
// result R, and a byte-wide display port driven over a 4-phase command handshake.
module bcd_alu_datapath #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_alu_datapath_if.slave  bus
);

  localparam int W     = 4 * DIGITS;
  localparam int HALF  = DIGITS / 2;
  localparam int CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] HALF_K = IDX_W'(HALF);

  localparam logic [2:0] CMD_CLEAR  = 3'd0;
  localparam logic [2:0] CMD_LOAD_A = 3'd1;
  localparam logic [2:0] CMD_LOAD_B = 3'd2;
  localparam logic [2:0] CMD_ADD    = 3'd3;
  localparam logic [2:0] CMD_SUB    = 3'd4;
  localparam logic [2:0] CMD_DISP_A = 3'd5;
  localparam logic [2:0] CMD_DISP_B = 3'd6;
  localparam logic [2:0] CMD_DISP_R = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic bcd_ok(input logic [7:0] d);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [7:0] d);
    logic [W+7:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  function automatic logic [7:0] pick_byte(input logic [W-1:0] v, input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < HALF; i++) begin
      b = (k == IDX_W'(i)) ? v[8*i +: 8] : b;
    end
    return b;
  endfunction

  state_t           state_r, next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             c_r;
  logic             sub_r;
  logic             cmd_ack_r;
  logic             busy_r;
  logic             carry_r;
  logic             err_r;
  logic [W-1:0]     a_r, b_r, r_r;
  logic [7:0]       out_r;

  logic [3:0]       a_dig_s, b_dig_s, dig_s;
  logic [4:0]       sum_s, dif_s;
  logic             c_nxt_s;
  logic             accept_s;
  logic             arith_s;
  logic [IDX_W-1:0] k_s;
  logic             k_in_s;

  assign accept_s = (state_r == IDLE) && bus.cmd_req;
  assign arith_s  = (bus.cmd == CMD_ADD) || (bus.cmd == CMD_SUB);
  assign k_s      = bus.bcd_input_data[IDX_W-1:0];
  assign k_in_s   = (k_s < HALF_K);

  // Digit slice for the current counter position and its BCD add/sub result
  always_comb begin
    a_dig_s = 4'd0;
    b_dig_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      a_dig_s = (cnt_r == CNT_W'(i)) ? a_r[4*i +: 4] : a_dig_s;
      b_dig_s = (cnt_r == CNT_W'(i)) ? b_r[4*i +: 4] : b_dig_s;
    end
    sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {4'd0, c_r};
    dif_s = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {4'd0, c_r};
    if (sub_r) begin
      if (dif_s[4]) begin
        dig_s   = dif_s[3:0] + 4'd10;
        c_nxt_s = 1'b1;
      end else begin
        dig_s   = dif_s[3:0];
        c_nxt_s = 1'b0;
      end
    end else begin
      if (sum_s > 5'd9) begin
        dig_s   = sum_s[3:0] - 4'd10;
        c_nxt_s = 1'b1;
      end else begin
        dig_s   = sum_s[3:0];
        c_nxt_s = 1'b0;
      end
    end
  end

  // Next-state logic; ACK is left only once the ack has been shown and req is low
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_req) begin
          next_s = arith_s ? RUN : ACK;
        end else begin
          next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          next_s = ACK;
        end else begin
          next_s = RUN;
        end
      end
      ACK: begin
        if (cmd_ack_r && !bus.cmd_req) begin
          next_s = IDLE;
        end else begin
          next_s = ACK;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // Control state: FSM, digit counter, carry chain, handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
      c_r       <= 1'b0;
      sub_r     <= 1'b0;
      cmd_ack_r <= 1'b0;
      carry_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s && arith_s) begin
            cnt_r <= '0;
            c_r   <= 1'b0;
            sub_r <= (bus.cmd == CMD_SUB);
          end else if (accept_s && (bus.cmd == CMD_CLEAR)) begin
            carry_r <= 1'b0;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CNT_W'(1);
          c_r   <= c_nxt_s;
          if (cnt_r == LAST) begin
            carry_r <= c_nxt_s;
          end
        end
        ACK: begin
          // Ack is raised on the first ACK edge, so a req dropped during RUN still sees a pulse
          if (!cmd_ack_r) begin
            cmd_ack_r <= 1'b1;
          end else if (!bus.cmd_req) begin
            cmd_ack_r <= 1'b0;
          end
        end
        default: cmd_ack_r <= 1'b0;
      endcase
    end
  end

  // Operand, result, display and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      r_r   <= '0;
      out_r <= 8'h00;
      err_r <= 1'b0;
    end else if (accept_s) begin
      case (bus.cmd)
        CMD_CLEAR: begin
          a_r   <= '0;
          b_r   <= '0;
          r_r   <= '0;
          out_r <= 8'h00;
          err_r <= 1'b0;
        end
        CMD_LOAD_A: begin
          if (bcd_ok(bus.bcd_input_data)) a_r <= shift_in(a_r, bus.bcd_input_data);
          else                            err_r <= 1'b1;
        end
        CMD_LOAD_B: begin
          if (bcd_ok(bus.bcd_input_data)) b_r <= shift_in(b_r, bus.bcd_input_data);
          else                            err_r <= 1'b1;
        end
        CMD_DISP_A: begin
          out_r <= pick_byte(a_r, k_s);
          if (!k_in_s) err_r <= 1'b1;
        end
        CMD_DISP_B: begin
          out_r <= pick_byte(b_r, k_s);
          if (!k_in_s) err_r <= 1'b1;
        end
        CMD_DISP_R: begin
          if (k_s == HALF_K) begin
            out_r <= {7'd0, carry_r};
          end else if (k_in_s) begin
            out_r <= pick_byte(r_r, k_s);
          end else begin
            out_r <= 8'h00;
            err_r <= 1'b1;
          end
        end
        default: begin
          out_r <= out_r;
        end
      endcase
    end else if (state_r == RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cnt_r == CNT_W'(i)) r_r[4*i +: 4] <= dig_s;
      end
    end else begin
      out_r <= out_r;
    end
  end

  assign bus.cmd_ack         = cmd_ack_r;
  assign bus.busy            = busy_r;
  assign bus.bcd_output_data = out_r;
  assign bus.carry           = carry_r;
  assign bus.err             = err_r;

endmodule

// File: tb/tb_bcd_alu_datapath.sv
// Directed self-checking bench for bcd_alu_datapath with DIGITS=4: loads, BCD
// add/sub with carry/borrow, display indexing, error handling, handshake and async reset.
module tb_bcd_alu_datapath;

  localparam logic [2:0] CLEAR  = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] ADD    = 3'd3;
  localparam logic [2:0] SUB    = 3'd4;
  localparam logic [2:0] DISP_A = 3'd5;
  localparam logic [2:0] DISP_B = 3'd6;
  localparam logic [2:0] DISP_R = 3'd7;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  bcd_alu_datapath_if bus();

  bcd_alu_datapath #(.DIGITS(4), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full 4-phase transaction; lat = edges from acceptance to cmd_ack rising
  task automatic send(input logic [2:0] c, input logic [7:0] d, output int lat);
    int n;
    @(posedge clk); #1;
    bus.cmd_req = 1'b1;
    bus.cmd = c;
    bus.bcd_input_data = d;
    @(posedge clk); #1;
    lat = 0;
    while (bus.cmd_ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (bus.cmd_ack !== 1'b1) $display("FAIL ack_timeout: cmd=%0d ack=%b required 1", c, bus.cmd_ack);
    else passed++;
    bus.cmd_req = 1'b0;
    n = 0;
    while (bus.cmd_ack !== 1'b0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (bus.cmd_ack !== 1'b0) $display("FAIL ack_release: cmd=%0d ack=%b required 0", c, bus.cmd_ack);
    else passed++;
  endtask

  task automatic disp(input logic [2:0] c, input logic [7:0] k, input logic [7:0] exp, input string name);
    int lat;
    send(c, k, lat);
    total++;
    if (bus.bcd_output_data !== exp) $display("FAIL %s: got %h required %h", name, bus.bcd_output_data, exp);
    else passed++;
  endtask

  task automatic load2(input logic [2:0] c, input logic [7:0] hi, input logic [7:0] lo);
    int lat;
    send(c, hi, lat);
    send(c, lo, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_req = 1'b0;
    bus.cmd = 3'd0;
    bus.bcd_input_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.cmd_ack, bus.busy, bus.carry, bus.err, bus.bcd_output_data} !== 12'h000)
      $display("FAIL reset_outputs: ack=%b busy=%b carry=%b err=%b out=%h required all 0",
               bus.cmd_ack, bus.busy, bus.carry, bus.err, bus.bcd_output_data);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_load_disp;
    int lat;
    send(LOAD_A, 8'h12, lat);
    total++;
    if (lat !== 1) $display("FAIL load_latency: got %0d required 1", lat);
    else passed++;
    send(LOAD_A, 8'h34, lat);
    total++;
    if (lat !== 1) $display("FAIL load_latency2: got %0d required 1", lat);
    else passed++;
    disp(DISP_A, 8'h01, 8'h12, "disp_a_k1");
    disp(DISP_A, 8'h00, 8'h34, "disp_a_k0");
    send(DISP_A, 8'h00, lat);
    total++;
    if (lat !== 1) $display("FAIL disp_latency: got %0d required 1", lat);
    else passed++;
  endtask

  task automatic test_add_carry;
    int lat;
    send(CLEAR, 8'h00, lat);
    load2(LOAD_A, 8'h99, 8'h99);
    load2(LOAD_B, 8'h00, 8'h01);
    send(ADD, 8'h00, lat);
    total++;
    if (lat !== 5) $display("FAIL add_latency: got %0d required 5", lat);
    else passed++;
    total++;
    if (bus.carry !== 1'b1) $display("FAIL add_carry: got %b required 1", bus.carry);
    else passed++;
    disp(DISP_R, 8'h00, 8'h00, "add_r_k0");
    disp(DISP_R, 8'h01, 8'h00, "add_r_k1");
    disp(DISP_R, 8'h02, 8'h01, "add_r_carry_byte");
  endtask

  task automatic test_sub;
    int lat;
    send(CLEAR, 8'h00, lat);
    load2(LOAD_A, 8'h00, 8'h03);
    load2(LOAD_B, 8'h00, 8'h05);
    send(SUB, 8'h00, lat);
    total++;
    if (bus.carry !== 1'b1) $display("FAIL sub_borrow: got %b required 1", bus.carry);
    else passed++;
    disp(DISP_R, 8'h00, 8'h98, "sub_neg_k0");
    disp(DISP_R, 8'h01, 8'h99, "sub_neg_k1");
    load2(LOAD_A, 8'h00, 8'h50);
    load2(LOAD_B, 8'h00, 8'h25);
    send(SUB, 8'h00, lat);
    total++;
    if (bus.carry !== 1'b0) $display("FAIL sub_noborrow: got %b required 0", bus.carry);
    else passed++;
    disp(DISP_R, 8'h00, 8'h25, "sub_pos_k0");
    disp(DISP_R, 8'h01, 8'h00, "sub_pos_k1");
  endtask

  task automatic test_errors;
    int lat;
    send(LOAD_B, 8'h3A, lat);
    total++;
    if (lat !== 1 || bus.err !== 1'b1) $display("FAIL bad_load: lat=%0d err=%b required 1/1", lat, bus.err);
    else passed++;
    disp(DISP_A, 8'h05, 8'h00, "disp_bad_index");
    total++;
    if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b required 1", bus.err);
    else passed++;
    disp(DISP_B, 8'h00, 8'h25, "b_unchanged");
    send(CLEAR, 8'h00, lat);
    total++;
    if ({bus.err, bus.carry, bus.bcd_output_data} !== 10'h000)
      $display("FAIL clear_outputs: err=%b carry=%b out=%h required 0", bus.err, bus.carry, bus.bcd_output_data);
    else passed++;
    disp(DISP_B, 8'h00, 8'h00, "clear_b");
    disp(DISP_A, 8'h00, 8'h00, "clear_a");
    disp(DISP_R, 8'h00, 8'h00, "clear_r");
  endtask

  task automatic test_handshake;
    int  lat;
    logic bad;
    load2(LOAD_A, 8'h04, 8'h58);
    load2(LOAD_B, 8'h03, 8'h67);
    @(posedge clk); #1;
    bus.cmd_req = 1'b1;
    bus.cmd = ADD;
    @(posedge clk); #1;
    bus.cmd_req = 1'b0;
    lat = 0;
    while (bus.cmd_ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 5) $display("FAIL pulse_latency: got %0d required 5", lat);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (bus.cmd_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL ack_pulse: ack=%b busy=%b required 0/0", bus.cmd_ack, bus.busy);
    else passed++;
    disp(DISP_R, 8'h00, 8'h25, "pulse_r_k0");
    disp(DISP_R, 8'h01, 8'h08, "pulse_r_k1");
    // Hold req high through ACK: a re-executed LOAD_A would shift A a second time
    @(posedge clk); #1;
    bus.cmd_req = 1'b1;
    bus.cmd = LOAD_A;
    bus.bcd_input_data = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bad = 1'b0;
    repeat (10) begin
      if (bus.cmd_ack !== 1'b1 || bus.busy !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL ack_hold: dropped=%b required 0", bad);
    else passed++;
    bus.cmd_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.cmd_ack !== 1'b0) $display("FAIL ack_hold_release: got %b required 0", bus.cmd_ack);
    else passed++;
    disp(DISP_A, 8'h01, 8'h58, "single_exec_k1");
    disp(DISP_A, 8'h00, 8'h77, "single_exec_k0");
  endtask

  task automatic test_async_reset;
    int lat;
    send(CLEAR, 8'h00, lat);
    load2(LOAD_A, 8'h99, 8'h99);
    load2(LOAD_B, 8'h00, 8'h02);
    send(ADD, 8'h00, lat);
    disp(DISP_R, 8'h00, 8'h01, "pre_reset_r");
    @(posedge clk); #1;
    bus.cmd_req = 1'b1;
    bus.cmd = ADD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    bus.cmd_req = 1'b0;
    #1;
    total++;
    if ({bus.cmd_ack, bus.busy, bus.carry} !== 3'b000)
      $display("FAIL async_reset: ack=%b busy=%b carry=%b required 0", bus.cmd_ack, bus.busy, bus.carry);
    else passed++;
    #3;
    rst_n = 1'b1;
    disp(DISP_R, 8'h00, 8'h00, "reset_r_k0");
    disp(DISP_R, 8'h02, 8'h00, "reset_carry_byte");
    send(LOAD_A, 8'h42, lat);
    send(ADD, 8'h00, lat);
    total++;
    if (lat !== 5) $display("FAIL post_reset_latency: got %0d required 5", lat);
    else passed++;
    disp(DISP_R, 8'h00, 8'h42, "post_reset_sum");
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_load_disp();
    test_add_carry();
    test_sub();
    test_errors();
    test_handshake();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
